// File: rtl/dispatch_buffer_if.sv
// Rename/issue-queue side bundle of the dispatch buffer.
// master: rename + issue queues, slave: the buffer.
interface dispatch_buffer_if #(
    parameter int W      = 4,
    parameter int NUM_IQ = 4
);
    logic [W-1:0]       IN_uopValid;
    logic [W*101-1:0]   IN_uop;
    logic [W-1:0]       IN_uopOrdering;
    logic               OUT_stall;
    logic [NUM_IQ-1:0]  IN_iqFull;
    logic [75:0]        IN_branch;
    logic               OUT_frontEn;
    logic [W-1:0]       OUT_uopValid;
    logic [W*101-1:0]   OUT_uop;
    logic [W-1:0]       OUT_uopOrdering;

    modport master (
        output IN_uopValid, IN_uop, IN_uopOrdering,
        output IN_iqFull, IN_branch,
        input  OUT_stall, OUT_frontEn,
        input  OUT_uopValid, OUT_uop, OUT_uopOrdering
    );

    modport slave (
        input  IN_uopValid, IN_uop, IN_uopOrdering,
        input  IN_iqFull, IN_branch,
        output OUT_stall, OUT_frontEn,
        output OUT_uopValid, OUT_uop, OUT_uopOrdering
    );
endinterface

// File: rtl/dispatch_buffer.sv
// Bundle FIFO between rename and the issue queues with mispredict kill.
// Define DISPATCH_STALL_CNT_EN to add the OUT_stallCycles counter.
module dispatch_buffer #(
    parameter int W      = 4,
    parameter int DEPTH  = 4,
    parameter int NUM_IQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    dispatch_buffer_if.slave  bus
`ifdef DISPATCH_STALL_CNT_EN
    ,
    output logic [31:0]       OUT_stallCycles
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int UW = 101;

    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW:0]     count;
    logic [W-1:0]    vld_q [DEPTH];
    logic [W*UW-1:0] uop_q [DEPTH];
    logic [W-1:0]    ord_q [DEPTH];

    logic [W-1:0] head_vld;
    logic         has_head;
    logic         br_v;
    logic [6:0]   br_sqn;
    logic         iq_full;
    logic         stall;
    logic         fe;
    logic         drop;
    logic         enq;
    logic         deq;
    logic         unused_br;

    // A lane is wrong-path when its sqN is strictly younger (7-bit wrap).
    function automatic logic younger(input logic [6:0] sq,
                                     input logic [6:0] br);
        logic [6:0] d;
        d = sq - br;
        return !d[6] && (d != 7'd0);
    endfunction

    assign br_v      = bus.IN_branch[0];
    assign br_sqn    = bus.IN_branch[43:37];
    assign unused_br = ^{bus.IN_branch[75:44], bus.IN_branch[36:1]};
    assign iq_full   = |bus.IN_iqFull;

    assign has_head = (count != '0);
    assign head_vld = has_head ? vld_q[rd_ptr] : '0;
    assign stall    = (count == (PW+1)'(DEPTH));
    assign fe       = (|head_vld) && !iq_full && !br_v;
    assign drop     = has_head && !(|head_vld);
    assign deq      = fe || drop;
    assign enq      = !stall && (|bus.IN_uopValid) && !br_v;

    assign bus.OUT_stall       = stall;
    assign bus.OUT_frontEn     = fe;
    assign bus.OUT_uopValid    = head_vld;
    assign bus.OUT_uop         = uop_q[rd_ptr];
    assign bus.OUT_uopOrdering = ord_q[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int e = 0; e < DEPTH; e++) vld_q[e] <= '0;
        end else begin
            if (enq) begin
                vld_q[wr_ptr] <= bus.IN_uopValid;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            // enq is blocked during a branch, so the kill never races a write
            if (br_v) begin
                for (int e = 0; e < DEPTH; e++)
                    for (int l = 0; l < W; l++)
                        if (younger(uop_q[e][l*UW+45 +: 7], br_sqn))
                            vld_q[e][l] <= 1'b0;
            end
            case ({enq, deq})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            uop_q[wr_ptr] <= bus.IN_uop;
            ord_q[wr_ptr] <= bus.IN_uopOrdering;
        end
    end

`ifdef DISPATCH_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            OUT_stallCycles <= '0;
        else if ((|head_vld) && iq_full && !br_v)
            OUT_stallCycles <= OUT_stallCycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_dispatch_buffer.sv
// Bench for dispatch_buffer: queue-based reference model checked every
// negedge, plus directed scenarios with literal expectations.
module tb_dispatch_buffer;
    localparam int W      = 4;
    localparam int DEPTH  = 4;
    localparam int NUM_IQ = 4;
    localparam int UW     = 101;
    localparam int BW     = W*UW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dispatch_buffer_if #(.W(W), .NUM_IQ(NUM_IQ)) bus ();

`ifdef DISPATCH_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    dispatch_buffer #(.W(W), .DEPTH(DEPTH), .NUM_IQ(NUM_IQ)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef DISPATCH_STALL_CNT_EN
        ,
        .OUT_stallCycles(stall_cycles)
`endif
    );

    typedef struct {
        logic [W-1:0]  v;
        logic [BW-1:0] u;
        logic [W-1:0]  o;
    } bundle_t;

    bundle_t     mq[$];
    int unsigned m_stall = 0;
    int          errors  = 0;
    int          checks  = 0;
    logic [BW-1:0] sent_u;
    logic [W-1:0]  sent_o;

    task automatic chk(input string name, input logic [BW-1:0] act,
                       input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue of bundles, updated per clock edge.
    always @(posedge clk or posedge rst) begin : model
        logic         br, full0, has, fe, drop;
        logic [W-1:0] hv;
        logic signed [6:0] d;
        if (rst) begin
            mq.delete();
            m_stall = 0;
        end else begin
            br    = bus.IN_branch[0];
            full0 = (mq.size() == DEPTH);
            has   = (mq.size() > 0);
            hv    = has ? mq[0].v : '0;
            fe    = has && (|hv) && !(|bus.IN_iqFull) && !br;
            drop  = has && (hv == '0);
            if (has && (|hv) && (|bus.IN_iqFull) && !br) m_stall++;
            if (br) begin
                foreach (mq[i])
                    for (int l = 0; l < W; l++) begin
                        d = mq[i].u[l*UW+45 +: 7] - bus.IN_branch[43:37];
                        if (d > 0) mq[i].v[l] = 1'b0;
                    end
            end
            if (fe || drop) void'(mq.pop_front());
            if (!full0 && (|bus.IN_uopValid) && !br)
                mq.push_back('{v: bus.IN_uopValid, u: bus.IN_uop,
                               o: bus.IN_uopOrdering});
        end
    end

    always @(negedge clk) begin : compare
        logic         has;
        logic [W-1:0] hv;
        has = (mq.size() > 0);
        hv  = has ? mq[0].v : '0;
        chk("stall", BW'(bus.OUT_stall), BW'(mq.size() == DEPTH));
        chk("valid", BW'(bus.OUT_uopValid), BW'(hv));
        chk("frontEn", BW'(bus.OUT_frontEn),
            BW'((|hv) && !(|bus.IN_iqFull) && !bus.IN_branch[0]));
        if (has) begin
            chk("uop", bus.OUT_uop, mq[0].u);
            chk("ordering", BW'(bus.OUT_uopOrdering), BW'(mq[0].o));
        end
`ifdef DISPATCH_STALL_CNT_EN
        chk("stallCycles", BW'(stall_cycles), BW'(m_stall));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [W-1:0] v, input int s0, input int s1,
                         input int s2, input int s3);
        logic [UW-1:0] u;
        int sq[4];
        sq = '{s0, s1, s2, s3};
        for (int l = 0; l < W; l++) begin
            u = UW'({$urandom, $urandom, $urandom, $urandom});
            u[51:45] = 7'(sq[l]);
            bus.IN_uop[l*UW +: UW] = u;
        end
        bus.IN_uopValid    = v;
        bus.IN_uopOrdering = W'($urandom);
    endtask

    task automatic idle();
        bus.IN_uopValid    = '0;
        bus.IN_uopOrdering = '0;
        bus.IN_uop         = '0;
    endtask

    task automatic branch(input int sq);
        logic [75:0] b;
        b         = 76'({$urandom, $urandom, $urandom});
        b[0]      = 1'b1;
        b[43:37]  = 7'(sq);
        bus.IN_branch = b;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.IN_iqFull = '0;
        bus.IN_branch = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", BW'(bus.OUT_uopValid), '0);
        chk("reset_stall", BW'(bus.OUT_stall), '0);

        // async reset with three bundles held
        bus.IN_iqFull = 4'b0001;
        tick();
        offer(4'b1111, 1, 2, 3, 4);   tick();
        offer(4'b1111, 5, 6, 7, 8);   tick();
        offer(4'b1111, 9, 10, 11, 12); tick();
        idle();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", BW'(bus.OUT_uopValid), '0);
        chk("rst_async_fe", BW'(bus.OUT_frontEn), '0);
        chk("rst_async_stall", BW'(bus.OUT_stall), '0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_valid", BW'(bus.OUT_uopValid), '0);

        // stall counter: empty cycles do not count, held head does
        bus.IN_iqFull = 4'b1000;
        repeat (3) tick();
        offer(4'b1111, 20, 21, 22, 23);
        tick();
        idle();
        repeat (7) tick();
        @(negedge clk);
`ifdef DISPATCH_STALL_CNT_EN
        chk("stall_cycles_7", BW'(stall_cycles), BW'(32'd7));
`endif
        tick();
        bus.IN_iqFull = '0;
        tick();

        // pass-through with a hole in lane 2
        offer(4'b1011, 10, 11, 99, 13);
        sent_u = bus.IN_uop;
        sent_o = bus.IN_uopOrdering;
        @(negedge clk);
        chk("latency_before", BW'(bus.OUT_uopValid), '0);
        tick();
        idle();
        @(negedge clk);
        chk("pass_valid", BW'(bus.OUT_uopValid), BW'(4'b1011));
        chk("pass_fe", BW'(bus.OUT_frontEn), BW'(1'b1));
        chk("pass_uop", bus.OUT_uop, sent_u);
        chk("pass_ord", BW'(bus.OUT_uopOrdering), BW'(sent_o));
        tick();
        @(negedge clk);
        chk("pass_after", BW'(bus.OUT_uopValid), '0);

        // back-pressure, then full buffer with dequeue
        bus.IN_iqFull = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            offer(4'b1111, 30+4*i, 31+4*i, 32+4*i, 33+4*i);
            tick();
        end
        offer(4'b1111, 50, 51, 52, 53);
        @(negedge clk);
        chk("bp_stall", BW'(bus.OUT_stall), BW'(1'b1));
        chk("bp_fe", BW'(bus.OUT_frontEn), '0);
        tick();
        bus.IN_iqFull = '0;
        @(negedge clk);
        chk("full_deq_fe", BW'(bus.OUT_frontEn), BW'(1'b1));
        chk("full_deq_stall", BW'(bus.OUT_stall), BW'(1'b1));
        chk("drain_sq0", BW'(bus.OUT_uop[51:45]), BW'(7'd30));
        tick();
        @(negedge clk);
        chk("refill_stall", BW'(bus.OUT_stall), '0);
        chk("drain_sq1", BW'(bus.OUT_uop[51:45]), BW'(7'd34));
        tick();
        idle();
        @(negedge clk);
        chk("drain_sq2", BW'(bus.OUT_uop[51:45]), BW'(7'd38));
        tick();
        @(negedge clk);
        chk("drain_sq3", BW'(bus.OUT_uop[51:45]), BW'(7'd42));
        tick();
        @(negedge clk);
        chk("drain_sq5th", BW'(bus.OUT_uop[51:45]), BW'(7'd50));
        chk("drain_5th_fe", BW'(bus.OUT_frontEn), BW'(1'b1));
        tick();
        @(negedge clk);
        chk("drain_empty", BW'(bus.OUT_uopValid), '0);

        // branch kill with IQ full and a discarded rename bundle
        bus.IN_iqFull = 4'b0010;
        offer(4'b1111, 5, 6, 7, 8);     tick();
        offer(4'b1111, 9, 10, 11, 12);  tick();
        offer(4'b1111, 60, 61, 62, 63);
        branch(6);
        tick();
        idle();
        bus.IN_branch = '0;
        bus.IN_iqFull = '0;
        @(negedge clk);
        chk("kill_head_valid", BW'(bus.OUT_uopValid), BW'(4'b0011));
        chk("kill_head_fe", BW'(bus.OUT_frontEn), BW'(1'b1));
        tick();
        @(negedge clk);
        chk("kill_empty_valid", BW'(bus.OUT_uopValid), '0);
        chk("kill_empty_fe", BW'(bus.OUT_frontEn), '0);
        tick();
        @(negedge clk);
        chk("kill_discard", BW'(bus.OUT_uopValid), '0);

        // sqN wrap-around kill
        bus.IN_iqFull = 4'b0001;
        offer(4'b1111, 126, 127, 0, 1);
        tick();
        idle();
        branch(127);
        tick();
        bus.IN_branch = '0;
        bus.IN_iqFull = '0;
        @(negedge clk);
        chk("wrap_valid", BW'(bus.OUT_uopValid), BW'(4'b0011));
        repeat (3) tick();
        @(negedge clk);
        chk("final_empty", BW'(bus.OUT_uopValid), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
